// File: rtl/alu_exec_unit.sv
`default_nettype none
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith/LUI ops and iterative SLL/SRL.
// Revision: 1.0
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   flush_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   stall_o,
  output logic                   illegal_o
);

  localparam logic [3:0] c_OP_LUI = 4'b0000;
  localparam logic [3:0] c_OP_OR  = 4'b0001;
  localparam logic [3:0] c_OP_SLL = 4'b0010;
  localparam logic [3:0] c_OP_ADD = 4'b0011;
  localparam logic [3:0] c_OP_SRL = 4'b0100;
  localparam logic [3:0] c_OP_SUB = 4'b0101;
  localparam logic [3:0] c_OP_AND = 4'b0110;
  localparam logic [3:0] c_OP_NOR = 4'b0111;
  localparam logic [SHAMT_WIDTH-1:0] c_SH_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
  localparam int c_HALF = DATA_WIDTH / 2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_zero;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_illegal;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic                    r_left;

  logic [DATA_WIDTH-1:0]   w_result;
  logic                    w_illegal;
  logic                    w_is_shift;
  logic                    w_long_shift;
  logic [DATA_WIDTH-1:0]   w_b_sl1;
  logic [DATA_WIDTH-1:0]   w_b_sr1;
  logic [DATA_WIDTH-1:0]   w_next_shreg;

  assign w_b_sl1      = {b_i[DATA_WIDTH-2:0], 1'b0};
  assign w_b_sr1      = {1'b0, b_i[DATA_WIDTH-1:1]};
  assign w_is_shift   = (alu_operation_i == c_OP_SLL) || (alu_operation_i == c_OP_SRL);
  assign w_long_shift = w_is_shift && (shamt_i > c_SH_ONE);
  assign w_next_shreg = r_left ? {r_shreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, r_shreg[DATA_WIDTH-1:1]};

  // Shift amounts of 0 and 1 resolve here; longer shifts take the iterative path.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (alu_operation_i)
      c_OP_LUI: w_result = {b_i[c_HALF-1:0], {c_HALF{1'b0}}};
      c_OP_OR:  w_result = a_i | b_i;
      c_OP_SLL: w_result = (shamt_i == '0) ? b_i : w_b_sl1;
      c_OP_ADD: w_result = a_i + b_i;
      c_OP_SRL: w_result = (shamt_i == '0) ? b_i : w_b_sr1;
      c_OP_SUB: w_result = a_i - b_i;
      c_OP_AND: w_result = a_i & b_i;
      c_OP_NOR: w_result = ~(a_i | b_i);
      default:  w_illegal = 1'b1;
    endcase
  end

  // The capture edge performs the first shift step so the result lands k cycles after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            if (w_long_shift) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
              r_left  <= (alu_operation_i == c_OP_SLL);
              r_shreg <= (alu_operation_i == c_OP_SLL) ? w_b_sl1 : w_b_sr1;
              r_cnt   <= shamt_i - c_SH_ONE;
            end else begin
              r_result  <= w_result;
              r_zero    <= (w_result == '0);
              r_done    <= 1'b1;
              r_illegal <= w_illegal;
            end
          end
        end
        S_SHIFT: begin
          if (flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_SH_ONE) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_result <= w_next_shreg;
            r_zero   <= (w_next_shreg == '0);
            r_done   <= 1'b1;
          end else begin
            r_shreg <= w_next_shreg;
            r_cnt   <= r_cnt - c_SH_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o  = r_result;
  assign zero_o    = r_zero;
  assign done_o    = r_done;
  assign busy_o    = r_busy;
  assign illegal_o = r_illegal;
  assign stall_o   = r_busy || ((r_state == S_IDLE) && start_i && w_long_shift && !flush_i);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against an arithmetic reference model.
// Revision: 1.0
module tb_alu_exec_unit;
  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset, start_i, flush_i;
  logic [3:0]    op;
  logic [DW-1:0] a, b;
  logic [SW-1:0] sh;
  logic [DW-1:0] result_o;
  logic          zero_o, done_o, busy_o, stall_o, illegal_o;

  int            n_checks = 0;
  int            n_err    = 0;
  logic [DW-1:0] last_res;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .alu_operation_i(op),
    .a_i(a), .b_i(b), .shamt_i(sh), .flush_i(flush_i),
    .result_o(result_o), .zero_o(zero_o), .done_o(done_o),
    .busy_o(busy_o), .stall_o(stall_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model(input logic [3:0] o, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y, input int k);
    case (o)
      4'd0:    return y << (DW / 2);
      4'd1:    return x | y;
      4'd2:    return y << k;
      4'd3:    return x + y;
      4'd4:    return y >> k;
      4'd5:    return x - y;
      4'd6:    return x & y;
      4'd7:    return ~(x | y);
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input int k, input string tag);
    int            lat;
    logic [DW-1:0] e;
    lat = ((o == 4'd2 || o == 4'd4) && k >= 2) ? k : 1;
    e   = model(o, x, y, k);
    op = o; a = x; b = y; sh = k[SW-1:0]; start_i = 1'b1;
    #1;
    chk({tag, " stall@N"}, stall_o, (lat > 1));
    tick();
    start_i = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, " busy"}, busy_o, 1);
      chk({tag, " early done"}, done_o, 0);
      chk({tag, " stall busy"}, stall_o, 1);
      tick();
    end
    chk({tag, " done"}, done_o, 1);
    chk({tag, " result"}, result_o, e);
    chk({tag, " zero"}, zero_o, (e == '0));
    chk({tag, " illegal"}, illegal_o, (o > 4'd7));
    chk({tag, " busy end"}, busy_o, 0);
    last_res = e;
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op = 4'd0; a = '0; b = '0; sh = '0;
    tick(); tick();
    chk("rst result", result_o, 0);
    chk("rst zero", zero_o, 1);
    chk("rst done", done_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst illegal", illegal_o, 0);
    chk("rst stall", stall_o, 0);
    reset = 1'b0;
    tick();

    run_op(4'd3, 32'h0000_0005, 32'hFFFF_FFFB, 0, "add zero");

    // Back-to-back SUBs: done_o must stay high two cycles in a row.
    op = 4'd5; a = 32'h1234; b = 32'h1234; start_i = 1'b1;
    tick();
    chk("sub1 done", done_o, 1);
    chk("sub1 result", result_o, 0);
    chk("sub1 zero", zero_o, 1);
    a = 32'd3; b = 32'd5;
    tick();
    chk("sub2 done", done_o, 1);
    chk("sub2 result", result_o, 32'hFFFF_FFFE);
    chk("sub2 zero", zero_o, 0);
    start_i = 1'b0;
    tick();
    chk("sub idle done", done_o, 0);
    last_res = 32'hFFFF_FFFE;

    run_op(4'd4, 32'h0, 32'h8000_0000, 4, "srl4");
    run_op(4'd2, 32'h0, 32'h0000_0001, 31, "sll31");

    // Flush at N+3 of an 8-bit shift: no completion, result held.
    op = 4'd2; b = 32'h0000_00A5; sh = 5'd8; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush busy", busy_o, 0);
    chk("flush stall", stall_o, 0);
    for (int i = 0; i < 7; i++) begin
      chk("flush no done", done_o, 0);
      chk("flush hold", result_o, last_res);
      tick();
    end

    // Reset at N+3 of the same shift.
    op = 4'd2; b = 32'h0000_00A5; sh = 5'd8; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst result", result_o, 0);
    chk("mid rst zero", zero_o, 1);
    chk("mid rst done", done_o, 0);
    chk("mid rst busy", busy_o, 0);
    chk("mid rst illegal", illegal_o, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("post rst no done", done_o, 0);
    end

    run_op(4'd0, 32'hDEAD_BEEF, 32'h0000_ABCD, 0, "lui");

    // Flush in the final shift cycle beats completion.
    op = 4'd4; b = 32'hF000_0000; sh = 5'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("final flush done", done_o, 0);
    chk("final flush busy", busy_o, 0);
    chk("final flush hold", result_o, 32'hABCD_0000);
    tick();
    chk("final flush later", done_o, 0);

    run_op(4'd7, 32'h0, 32'h0, 0, "nor");
    run_op(4'd9, 32'h1111_1111, 32'h2222_2222, 0, "illegal");
    run_op(4'd4, 32'h0, 32'h0000_0055, 0, "srl0");
    run_op(4'd2, 32'h0, 32'h8000_0001, 1, "sll1");

    // start_i held with a different op during a shift is ignored until IDLE.
    op = 4'd4; b = 32'hF000_0000; sh = 5'd5; start_i = 1'b1;
    tick();
    op = 4'd3; a = 32'h10; b = 32'h20; sh = 5'd0;
    for (int i = 1; i < 5; i++) begin
      chk("held busy", busy_o, 1);
      chk("held no done", done_o, 0);
      tick();
    end
    chk("held shift done", done_o, 1);
    chk("held shift result", result_o, 32'h0780_0000);
    tick();
    chk("held add done", done_o, 1);
    chk("held add result", result_o, 32'h30);
    chk("held add busy", busy_o, 0);
    start_i = 1'b0;
    tick();
    chk("held idle", done_o, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ro = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd4;
      run_op(ro, $urandom, $urandom, int'($urandom_range(0, 31)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
